pp_rd_scheduler: RTL and testbench

- Round-robin read scheduler between the peripheral group controllers (UART and GPIO groups) and the encoder.
- Arbitrates the per-group interrupt lines and issues one read request at a time to the encoder with a one-hot slave id.
- Tracks the request through encoder acceptance (rd_req_ack) and group service completion (int_ack).
- Adds a request timeout and a post-service holdoff so that a group's slow interrupt deassertion cannot produce a double grant.

---
 rtl/pp_rd_scheduler_pkg.sv | 16 +
 rtl/pp_rd_scheduler_if.sv | 29 ++
 rtl/pp_rd_scheduler_rr_pick.sv | 34 +++
 rtl/pp_rd_scheduler.sv | 123 ++++++++++++
 tb/tb_pp_rd_scheduler.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/pp_rd_scheduler_pkg.sv
// rtl/pp_rd_scheduler_pkg.sv - state encoding and width helper shared by the read scheduler files
package pp_rd_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_HOLDOFF = 2'd3
  } sched_state_t;

  // Group index width; a single group still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pp_rd_scheduler_if.sv
// rtl/pp_rd_scheduler_if.sv - group/encoder handshake bundle for the read scheduler
interface pp_rd_scheduler_if
  import pp_rd_scheduler_pkg::*;
#(
  parameter int TOTAL_GRP = 2
);
  localparam int LG_WIDTH = idx_width(TOTAL_GRP);

  logic [TOTAL_GRP-1:0] i_interrupt;
  logic [TOTAL_GRP-1:0] int_mask;
  logic                 rd_req_ack;
  logic [TOTAL_GRP-1:0] int_ack;
  logic                 rd_req;
  logic [TOTAL_GRP-1:0] rd_slave_id;
  logic                 busy;
  logic                 timeout_err;
  logic [LG_WIDTH-1:0]  last_grant;

  modport master (
    input  i_interrupt, int_mask, rd_req_ack, int_ack,
    output rd_req, rd_slave_id, busy, timeout_err, last_grant
  );

  modport slave (
    output i_interrupt, int_mask, rd_req_ack, int_ack,
    input  rd_req, rd_slave_id, busy, timeout_err, last_grant
  );

endinterface

// File: rtl/pp_rd_scheduler_rr_pick.sv
// rtl/pp_rd_scheduler_rr_pick.sv - combinational round-robin picker (doubled-vector rotate + priority)
module pp_rr_pick #(
  parameter int TOTAL_GRP = 2,
  parameter int IDX_W     = 1
) (
  input  logic [TOTAL_GRP-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [TOTAL_GRP-1:0] grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 valid
);

  logic [2*TOTAL_GRP-1:0] dbl;
  logic [TOTAL_GRP-1:0]   rot;
  int                     start;
  int                     off;
  int                     win;

  always_comb begin
    start = (int'(last) + 1) % TOTAL_GRP;
    dbl   = {req, req};
    rot   = TOTAL_GRP'(dbl >> start);
    off   = 0;
    // Downward scan leaves the lowest set offset, i.e. the first requester after last.
    for (int i = TOTAL_GRP - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    win   = (start + off) % TOTAL_GRP;
    valid = |req;
    idx   = IDX_W'(win);
    grant = valid ? (TOTAL_GRP'(1) << win) : '0;
  end

endmodule

// File: rtl/pp_rd_scheduler.sv
// rtl/pp_rd_scheduler.sv - round-robin read scheduler between peripheral groups and the encoder
module pp_rd_scheduler
  import pp_rd_scheduler_pkg::*;
#(
  parameter int TOTAL_GRP      = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic                clk,
  input logic                rst_n,
  pp_rd_scheduler_if.master  bus
);

  localparam int LG_WIDTH = idx_width(TOTAL_GRP);
  localparam logic [CNT_WIDTH-1:0] TO_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST =
    CNT_WIDTH'((HOLDOFF_CYCLES == 0) ? 0 : HOLDOFF_CYCLES - 1);

  sched_state_t         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rd_req_q, rd_req_d;
  logic [TOTAL_GRP-1:0] slave_q, slave_d;
  logic                 busy_q, busy_d;
  logic                 terr_q, terr_d;
  logic [LG_WIDTH-1:0]  last_q, last_d;

  logic [TOTAL_GRP-1:0] pend;
  logic [TOTAL_GRP-1:0] pick_grant;
  logic [LG_WIDTH-1:0]  pick_idx;
  logic                 pick_valid;

  assign pend = bus.i_interrupt & ~bus.int_mask;

  pp_rr_pick #(
    .TOTAL_GRP (TOTAL_GRP),
    .IDX_W     (LG_WIDTH)
  ) u_pick (
    .req   (pend),
    .last  (last_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_req_d = rd_req_q;
    slave_d  = slave_q;
    last_d   = last_q;
    terr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_REQ;
          rd_req_d = 1'b1;
          slave_d  = pick_grant;
          last_d   = pick_idx;
          cnt_d    = '0;
        end
      end
      ST_REQ: begin
        // An ack on the final cycle beats the timeout.
        if (bus.rd_req_ack) begin
          state_d  = ST_SERVICE;
          rd_req_d = 1'b0;
        end else if (cnt_q == TO_LAST) begin
          state_d  = ST_HOLDOFF;
          rd_req_d = 1'b0;
          slave_d  = '0;
          terr_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_SERVICE: begin
        if ((bus.int_ack & slave_q) != '0) begin
          state_d = ST_HOLDOFF;
          slave_d = '0;
          cnt_d   = '0;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q >= HOLD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_req_q <= 1'b0;
      slave_q  <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      last_q   <= LG_WIDTH'(TOTAL_GRP - 1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_req_q <= rd_req_d;
      slave_q  <= slave_d;
      busy_q   <= busy_d;
      terr_q   <= terr_d;
      last_q   <= last_d;
    end
  end

  assign bus.rd_req      = rd_req_q;
  assign bus.rd_slave_id = slave_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = terr_q;
  assign bus.last_grant  = last_q;

endmodule

// File: tb/tb_pp_rd_scheduler.sv
// tb/tb_pp_rd_scheduler.sv - randomized self-checking bench for pp_rd_scheduler against a transaction model
module tb_pp_rd_scheduler;

  localparam int N  = 4;
  localparam int TO = 8;
  localparam int HO = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pp_rd_scheduler_if #(.TOTAL_GRP(N)) bus ();

  pp_rd_scheduler #(
    .TOTAL_GRP      (N),
    .TIMEOUT_CYCLES (TO),
    .HOLDOFF_CYCLES (HO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int last_m = N - 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_win(input logic [N-1:0] p, input int last);
    for (int k = 1; k <= N; k++) begin
      if (p[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic holdoff_check();
    bus.i_interrupt = '1;
    bus.int_mask    = '0;
    for (int i = 1; i < HO; i++) begin
      @(negedge clk);
      check("hold_busy", bus.busy, 1);
      check("hold_req", bus.rd_req, 0);
    end
    @(negedge clk);
    check("idle_busy", bus.busy, 0);
    check("idle_req", bus.rd_req, 0);
  endtask

  task automatic do_txn(input logic [N-1:0] intr, input logic [N-1:0] mask,
                        input int ack_d, input int svc_d,
                        input bit stray, input bit withdraw, input bit rst_svc);
    logic [N-1:0] oh;
    logic [N-1:0] other;
    int w;
    int hi;
    bit timed_out;
    w     = rr_win(intr & ~mask, last_m);
    oh    = '0;
    oh[w] = 1'b1;
    other = '0;
    other[(w + 1) % N] = 1'b1;
    timed_out = (ack_d >= TO);
    bus.i_interrupt = intr;
    bus.int_mask    = mask;
    @(negedge clk);
    check("grant_req", bus.rd_req, 1);
    check("grant_id", bus.rd_slave_id, oh);
    check("grant_last", bus.last_grant, w);
    check("grant_busy", bus.busy, 1);
    last_m = w;
    if (withdraw) bus.i_interrupt = '0;
    if (stray) bus.int_mask = ~mask;
    hi = 1;
    for (int c = 0; c < TO; c++) begin
      bus.rd_req_ack = (c == ack_d);
      bus.int_ack    = stray ? oh : '0;
      @(negedge clk);
      bus.rd_req_ack = 1'b0;
      bus.int_ack    = '0;
      if (c == ack_d || c == TO - 1) break;
      if (bus.rd_req === 1'b1 && bus.rd_slave_id === oh) hi++;
    end
    check("req_hold_cycles", hi, timed_out ? TO : ack_d + 1);
    if (timed_out) begin
      check("to_req", bus.rd_req, 0);
      check("to_id", bus.rd_slave_id, 0);
      check("to_err", bus.timeout_err, 1);
      check("to_last", bus.last_grant, w);
      holdoff_check_to();
      return;
    end
    check("ack_req", bus.rd_req, 0);
    check("ack_id", bus.rd_slave_id, oh);
    check("ack_err", bus.timeout_err, 0);
    check("ack_busy", bus.busy, 1);
    if (rst_svc) begin
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", bus.rd_req, 0);
      check("arst_id", bus.rd_slave_id, 0);
      check("arst_busy", bus.busy, 0);
      check("arst_err", bus.timeout_err, 0);
      check("arst_last", bus.last_grant, N - 1);
      @(negedge clk);
      rst_n  = 1'b1;
      last_m = N - 1;
      return;
    end
    for (int s = 0; s < svc_d; s++) begin
      bus.int_ack    = stray ? other : '0;
      bus.rd_req_ack = stray;
      @(negedge clk);
      bus.int_ack    = '0;
      bus.rd_req_ack = 1'b0;
    end
    check("svc_id", bus.rd_slave_id, oh);
    check("svc_req", bus.rd_req, 0);
    bus.int_ack = oh;
    @(negedge clk);
    bus.int_ack = '0;
    check("done_id", bus.rd_slave_id, 0);
    check("done_busy", bus.busy, 1);
    holdoff_check();
  endtask

  // Timeout enters holdoff on the same edge that raises the error pulse.
  task automatic holdoff_check_to();
    bus.i_interrupt = '1;
    bus.int_mask    = '0;
    @(negedge clk);
    check("to_pulse_end", bus.timeout_err, 0);
    check("to_hold_busy", bus.busy, (HO > 1) ? 1 : 0);
    for (int i = 2; i < HO; i++) begin
      @(negedge clk);
      check("to_hold_busy", bus.busy, 1);
    end
    if (HO > 1) @(negedge clk);
    check("to_idle_busy", bus.busy, 0);
    check("to_idle_req", bus.rd_req, 0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_interrupt = N'($urandom);
      bus.int_mask    = '1;
      @(negedge clk);
      check("gap_busy", bus.busy, 0);
      check("gap_req", bus.rd_req, 0);
    end
  endtask

  logic [N-1:0] ri, rm;

  initial begin
    bus.i_interrupt = '0;
    bus.int_mask    = '0;
    bus.rd_req_ack  = 1'b0;
    bus.int_ack     = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", bus.rd_req, 0);
    check("rst_id", bus.rd_slave_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.timeout_err, 0);
    check("rst_last", bus.last_grant, N - 1);
    @(negedge clk);
    rst_n = 1'b1;

    do_txn(4'b0001, 4'b0000, 3, 0, 1'b0, 1'b0, 1'b0);
    do_txn(4'b0010, 4'b0000, TO + 3, 0, 1'b0, 1'b0, 1'b0);
    do_txn(4'b0011, 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
    check("after_to_group0", bus.last_grant, 0);
    do_txn(4'b0100, 4'b0000, TO - 1, 1, 1'b0, 1'b0, 1'b0);
    do_txn(4'b0011, 4'b0001, 1, 2, 1'b1, 1'b0, 1'b0);
    do_txn(4'b1000, 4'b0000, 2, 1, 1'b0, 1'b1, 1'b0);
    do_txn(4'b0110, 4'b0000, 0, 1, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 5; r++) begin
      do_txn(4'b1111, 4'b0000, 0, 0, 1'b0, 1'b0, 1'b0);
      check("rr_order", bus.last_grant, r % N);
    end

    for (int t = 0; t < 40; t++) begin
      ri = '0;
      rm = '0;
      while ((ri & ~rm) == '0) begin
        ri = N'($urandom);
        rm = N'($urandom & $urandom);
      end
      do_txn(ri, rm, $urandom_range(0, TO + 1), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 9) == 0));
      idle_gap($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
